ukf_column_packer: RTL and testbench

UKF_COLUMN_PACKER -- requirements
Module: ukf_column_packer

---
 rtl/ukf_column_packer_if.sv | 38 +++
 rtl/ukf_column_packer.sv | 134 +++++++++++++
 tb/tb_ukf_column_packer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ukf_column_packer_if.sv
// Bus bundle for ukf_column_packer: command, input word stream and packed output beats.
// slave is the packer side, master is the producer/consumer side.
interface ukf_column_packer_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int IDX_W  = 4
);
  logic                    start;
  logic [IDX_W-1:0]        matrix_size;
  logic [IDX_W-1:0]        parallel_units;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        out_mask;
  logic                    out_is_diag;
  logic                    out_col_end;
  logic                    out_last;
  logic [IDX_W-1:0]        out_col;
  logic [IDX_W-1:0]        out_row;
  logic                    busy;
  logic                    done;
  logic                    err_cfg;

  modport slave (
    input  start, matrix_size, parallel_units, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_is_diag, out_col_end,
           out_last, out_col, out_row, busy, done, err_cfg
  );

  modport master (
    output start, matrix_size, parallel_units, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_is_diag, out_col_end,
           out_last, out_col, out_row, busy, done, err_cfg
  );
endinterface

// File: rtl/ukf_column_packer.sv
// Packs a column-major lower-triangular matrix stream into beats: one diagonal
// beat per column, then the sub-diagonal rows in packs of up to P lanes.
module ukf_column_packer #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int IDX_W  = 4
) (
  input logic                clock,
  input logic                reset,
  ukf_column_packer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIAG, LOWER, PRESENT} state_t;

  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] LANES_I = IDX_W'(LANES);

  state_t                  state_q;
  logic [IDX_W-1:0]        n_q, p_q, col_q, row_q, cnt_q, out_row_q;
  logic [LANES*DATA_W-1:0] data_q;
  logic [LANES-1:0]        mask_q;
  logic                    diag_q, col_end_q, last_q, busy_q, done_q, err_q;

  logic [IDX_W-1:0] last_idx;
  logic             cfg_bad;
  logic             close_pack;

  assign last_idx   = n_q - ONE;
  assign cfg_bad    = (bus.matrix_size == '0) || (bus.parallel_units == '0) ||
                      (bus.parallel_units > LANES_I);
  assign close_pack = ((cnt_q + ONE) == p_q) || (row_q == last_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      p_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      out_row_q <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      diag_q    <= 1'b0;
      col_end_q <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              n_q     <= bus.matrix_size;
              p_q     <= bus.parallel_units;
              col_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= DIAG;
            end
          end
        end
        DIAG: begin
          if (bus.in_valid) begin
            data_q                <= '0;
            data_q[DATA_W-1:0]    <= bus.in_data;
            mask_q                <= LANES'(1);
            diag_q                <= 1'b1;
            // Last column has no sub-diagonal rows, so its diagonal closes it.
            col_end_q             <= (col_q == last_idx);
            last_q                <= (col_q == last_idx);
            out_row_q             <= col_q;
            row_q                 <= col_q + ONE;
            state_q               <= PRESENT;
          end
        end
        LOWER: begin
          if (bus.in_valid) begin
            for (int unsigned k = 0; k < LANES; k++) begin
              if (cnt_q == IDX_W'(k)) begin
                data_q[k*DATA_W +: DATA_W] <= bus.in_data;
                mask_q[k]                  <= 1'b1;
              end
            end
            row_q <= row_q + ONE;
            cnt_q <= cnt_q + ONE;
            if (close_pack) begin
              col_end_q <= (row_q == last_idx);
              state_q   <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (bus.out_ready) begin
            data_q    <= '0;
            mask_q    <= '0;
            diag_q    <= 1'b0;
            col_end_q <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            if (last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else if (col_end_q) begin
              col_q   <= col_q + ONE;
              state_q <= DIAG;
            end else begin
              out_row_q <= row_q;
              state_q   <= LOWER;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == DIAG) || (state_q == LOWER);
  assign bus.out_valid   = (state_q == PRESENT);
  assign bus.out_data    = data_q;
  assign bus.out_mask    = mask_q;
  assign bus.out_is_diag = diag_q;
  assign bus.out_col_end = col_end_q;
  assign bus.out_last    = last_q;
  assign bus.out_col     = col_q;
  assign bus.out_row     = out_row_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_cfg     = err_q;
endmodule

// File: tb/tb_ukf_column_packer.sv
// Directed bench for ukf_column_packer: inputs driven and outputs sampled on the
// falling edge; expected beats come from a column/pack walk of the matrix.
module tb_ukf_column_packer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   pass  = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   last_cnt = 0;

  always #5 clock = ~clock;

  ukf_column_packer_if #(.DATA_W(32), .LANES(4), .IDX_W(4)) bus ();

  ukf_column_packer #(.DATA_W(32), .LANES(4), .IDX_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clock) begin
    if (bus.done) done_cnt++;
    if (bus.out_valid && bus.out_ready && bus.out_last) last_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int mode, input int k);
    if (mode == 0) return (k == 0) ? 32'h4000_0000 : 32'h3f80_0000;
    return 32'h3f80_0000 + 32'(k * 3 + 1);
  endfunction

  function automatic logic [127:0] all_outs();
    return {bus.out_data[127:48], bus.out_valid, bus.in_ready, bus.busy, bus.done,
            bus.err_cfg, bus.out_mask, bus.out_col, bus.out_row, bus.out_is_diag,
            bus.out_col_end, bus.out_last} | {80'b0, bus.out_data[47:0]};
  endfunction

  task automatic push(input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) break;
      @(negedge clock);
    end
    if (!bus.in_ready) begin
      check("push_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid) break;
      @(negedge clock);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [127:0] ed, input logic [3:0] em,
                     input logic [2:0] eflags, input logic [3:0] ecol,
                     input logic [3:0] erow, input int stall);
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid) break;
      @(negedge clock);
    end
    if (!bus.out_valid) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      check($sformatf("%s_stall%0d", tag, s),
            {bus.out_data[123:0], bus.in_ready, bus.out_valid, bus.out_is_diag, bus.out_col_end},
            {ed[123:0], 1'b0, 1'b1, eflags[2:1]});
      @(negedge clock);
    end
    check({tag, "_data"}, bus.out_data, ed);
    check({tag, "_mask"}, bus.out_mask, em);
    check({tag, "_flags"}, {bus.out_is_diag, bus.out_col_end, bus.out_last}, eflags);
    check({tag, "_col_row"}, {bus.out_col, bus.out_row}, {ecol, erow});
    check({tag, "_inrdy"}, bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_matrix(input string name, input int n, input int p, input int mode,
                            input int stall_beat, input bit poke, input int exp_beats);
    int k, beats, r, cnt, row0, d0, l0;
    logic [127:0] d;
    logic [3:0]   m;
    k = 0;
    beats = 0;
    d0 = done_cnt;
    l0 = last_cnt;
    bus.matrix_size    = 4'(n);
    bus.parallel_units = 4'(p);
    bus.start          = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check({name, "_busy_on"}, {bus.busy, bus.in_ready, bus.out_valid}, 3'b110);
    if (poke) begin
      bus.matrix_size    = 4'd2;
      bus.parallel_units = 4'd3;
      bus.start          = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
    end
    for (int j = 0; j < n; j++) begin
      push(word(mode, k));
      d = '0;
      d[31:0] = word(mode, k);
      k++;
      pop($sformatf("%s_c%0d_diag", name, j), d, 4'b0001,
          {1'b1, j == n - 1, j == n - 1}, 4'(j), 4'(j), (beats == stall_beat) ? 5 : 0);
      beats++;
      r = j + 1;
      while (r < n) begin
        cnt  = 0;
        d    = '0;
        m    = '0;
        row0 = r;
        while (cnt < p && r < n) begin
          push(word(mode, k));
          d[cnt*32 +: 32] = word(mode, k);
          m[cnt] = 1'b1;
          k++;
          r++;
          cnt++;
        end
        pop($sformatf("%s_c%0d_r%0d", name, j, row0), d, m, {1'b0, r == n, 1'b0},
            4'(j), 4'(row0), (beats == stall_beat) ? 5 : 0);
        beats++;
      end
    end
    check({name, "_done_pulse"}, {bus.done, bus.busy}, 2'b10);
    @(negedge clock);
    check({name, "_done_clear"}, {bus.done, bus.busy}, 2'b00);
    check({name, "_beats"}, beats, exp_beats);
    check({name, "_words"}, k, n * (n + 1) / 2);
    check({name, "_last_done_cnt"}, {32'(last_cnt - l0), 32'(done_cnt - d0)}, {32'd1, 32'd1});
  endtask

  task automatic err_start(input string name, input int n, input int p);
    bus.matrix_size    = 4'(n);
    bus.parallel_units = 4'(p);
    bus.start          = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check({name, "_pulse"}, {bus.err_cfg, bus.busy, bus.in_ready}, 3'b100);
    @(negedge clock);
    check({name, "_after"}, {bus.err_cfg, bus.busy, bus.in_ready}, 3'b000);
  endtask

  initial begin
    int d0;
    bus.start          = 1'b0;
    bus.matrix_size    = '0;
    bus.parallel_units = '0;
    bus.in_valid       = 1'b0;
    bus.in_data        = '0;
    bus.out_ready      = 1'b0;

    @(negedge clock);
    @(negedge clock);
    check("reset_state", all_outs(), 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_state", all_outs(), 0);

    err_start("err_p0", 3, 0);
    err_start("err_p5", 3, 5);
    err_start("err_n0", 0, 2);

    run_matrix("n3p4", 3, 4, 0, 1, 1'b0, 5);
    run_matrix("n12p4", 12, 4, 1, -1, 1'b0, 33);
    run_matrix("n4p1", 4, 1, 1, -1, 1'b1, 10);

    // Abort mid-matrix after 10 words: diag, 4, 4 drained, one word staged.
    d0 = done_cnt;
    bus.matrix_size    = 4'd12;
    bus.parallel_units = 4'd4;
    bus.start          = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    push(32'h1111_0000);
    drain();
    for (int i = 0; i < 4; i++) push(32'h2222_0000 + 32'(i));
    drain();
    for (int i = 0; i < 4; i++) push(32'h3333_0000 + 32'(i));
    drain();
    push(32'h4444_0000);
    check("abort_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_outs", all_outs(), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clock);
    check("abort_no_done", {32'(done_cnt - d0), 31'b0, bus.busy}, 0);
    run_matrix("n1p1", 1, 1, 1, -1, 1'b0, 1);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
